mux_scan_reg: RTL and testbench

- Parametrised, registered N-channel, W-bit multiplexer with a valid/ready output stage.
- Two selection modes: manual (loaded select) and auto-scan (round-robin with a programmable dwell per channel).
- Sits between multiple sampled sources and a single downstream consumer.
- Generation successor to the fixed 8:1 single-bit combinational mux.

---
 rtl/mux_scan_if.sv | 29 ++
 rtl/mux_scan_reg.sv | 76 +++++++
 tb/tb_mux_scan_reg.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_if.sv
// mux_scan_if: channel inputs, select controls and the valid/ready output
// stage of mux_scan_reg, grouped so producer and consumer wiring travels as one.
interface mux_scan_if #(
   parameter int NCH = 8,
   parameter int DW  = 8
);
   localparam int SELW = ($clog2(NCH) < 1) ? 1 : $clog2(NCH);

   logic [NCH*DW-1:0] in_data;
   logic [NCH-1:0]    in_valid;
   logic              mode;
   logic [SELW-1:0]   sel_in;
   logic              sel_load;
   logic [DW-1:0]     out_data;
   logic              out_valid;
   logic              out_ready;
   logic [SELW-1:0]   out_sel;
   logic              sel_err;

   modport master (
      output in_data, in_valid, mode, sel_in, sel_load, out_ready,
      input  out_data, out_valid, out_sel, sel_err
   );

   modport slave (
      input  in_data, in_valid, mode, sel_in, sel_load, out_ready,
      output out_data, out_valid, out_sel, sel_err
   );
endinterface

// File: rtl/mux_scan_reg.sv
// mux_scan_reg: registered NCH-way, DW-bit multiplexer with a valid/ready
// output stage. The channel is either loaded explicitly (manual mode) or
// stepped round-robin, DWELL accepted beats per channel (scan mode).
module mux_scan_reg #(
   parameter int NCH   = 8,
   parameter int DW    = 8,
   parameter int DWELL = 4
) (
   input logic       clk,
   input logic       rst_n,
   mux_scan_if.slave bus
);
   localparam int SELW = ($clog2(NCH) < 1) ? 1 : $clog2(NCH);
   localparam int CW   = $clog2(DWELL + 1);
   localparam logic [SELW-1:0] SEL_LAST   = SELW'(NCH - 1);
   localparam logic [CW-1:0]   DWELL_LAST = CW'(DWELL - 1);

   logic [SELW-1:0] cur_sel;
   logic [CW-1:0]   dwell_cnt;
   logic            stall;
   logic            load_ok;
   logic            load_bad;
   logic [SELW-1:0] sel_next;
   logic [DW-1:0]   cur_data;
   logic            cur_valid;

   // Decode stall, legality of a select load, the wrap-around successor and the addressed channel
   always_comb begin
      stall     = bus.out_valid && !bus.out_ready;
      load_ok   = bus.sel_load && (int'(bus.sel_in) < NCH);
      load_bad  = bus.sel_load && !(int'(bus.sel_in) < NCH);
      sel_next  = (cur_sel == SEL_LAST) ? '0 : cur_sel + 1'b1;
      cur_data  = bus.in_data[int'(cur_sel)*DW +: DW];
      cur_valid = bus.in_valid[cur_sel];
   end

   // Select state: loads win over scan stepping; an illegal load leaves everything as is
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_sel     <= '0;
         dwell_cnt   <= '0;
         bus.sel_err <= 1'b0;
      end else begin
         bus.sel_err <= load_bad;
         if (load_ok) begin
            cur_sel   <= bus.sel_in;
            dwell_cnt <= '0;
         end else if (!load_bad) begin
            if (!bus.mode) begin
               // manual: dwell parked at 0 so a later switch to scan starts a fresh dwell
               dwell_cnt <= '0;
            end else if (!stall) begin
               if (dwell_cnt == DWELL_LAST) begin
                  dwell_cnt <= '0;
                  cur_sel   <= sel_next;
               end else begin
                  dwell_cnt <= dwell_cnt + 1'b1;
               end
            end
         end
      end
   end

   // Output register: capture the addressed channel unless the consumer is holding a beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_data  <= '0;
         bus.out_valid <= 1'b0;
         bus.out_sel   <= '0;
      end else if (!stall) begin
         bus.out_data  <= cur_data;
         bus.out_valid <= cur_valid;
         bus.out_sel   <= cur_sel;
      end
   end
endmodule

// File: tb/tb_mux_scan_reg.sv
// tb_mux_scan_reg: directed scenarios plus a randomized run of mux_scan_reg
// (NCH=8, DWELL=4) against a position-based reference model, and a second
// instance (NCH=5, DWELL=1) for non-power-of-2 wrap and illegal selects.
module tb_mux_scan_reg;
   localparam int NCH    = 8;
   localparam int DW     = 8;
   localparam int DWELL  = 4;
   localparam int SELW   = $clog2(NCH);
   localparam int NCH2   = 5;
   localparam int DWELL2 = 1;
   localparam int SELW2  = $clog2(NCH2);

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   mux_scan_if #(.NCH(NCH),  .DW(DW)) bi ();
   mux_scan_if #(.NCH(NCH2), .DW(DW)) bj ();

   mux_scan_reg #(.NCH(NCH), .DW(DW), .DWELL(DWELL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bi)
   );

   mux_scan_reg #(.NCH(NCH2), .DW(DW), .DWELL(DWELL2)) dut5 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bj)
   );

   // free-running clock, period 10
   always #5 clk = ~clk;

   // Reference model for the main instance: the scan position counts beats
   // linearly over all channels; the channel is position / DWELL.
   int             pos;
   logic [DW-1:0]  e_data;
   logic           e_valid;
   int             e_sel;
   logic           e_err;

   task automatic model_reset();
      pos = 0; e_data = '0; e_valid = 1'b0; e_sel = 0; e_err = 1'b0;
   endtask

   task automatic model_edge();
      int ch;
      bit hold;
      ch   = pos / DWELL;
      hold = e_valid && !bi.out_ready;
      if (!hold) begin
         e_data  = bi.in_data[ch*DW +: DW];
         e_valid = bi.in_valid[ch];
         e_sel   = ch;
      end
      e_err = bi.sel_load && (int'(bi.sel_in) >= NCH);
      if (bi.sel_load) begin
         if (int'(bi.sel_in) < NCH) pos = int'(bi.sel_in) * DWELL;
      end else if (!bi.mode) begin
         pos = ch * DWELL;
      end else if (!hold) begin
         pos = (pos + 1) % (NCH * DWELL);
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int base);
      for (int k = 0; k < NCH; k++) bi.in_data[k*DW +: DW] = DW'(base + k);
   endtask

   task automatic set_data2(input int base);
      for (int k = 0; k < NCH2; k++) bj.in_data[k*DW +: DW] = DW'(base + k);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (bi.out_data !== 8'h00 || bi.out_valid !== 1'b0 || bi.out_sel !== 3'd0 || bi.sel_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_initial: data=%h valid=%b sel=%0d err=%b, required all zero",
                  bi.out_data, bi.out_valid, bi.out_sel, bi.sel_err);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      bi.mode = 1'b0; bi.out_ready = 1'b1; bi.in_valid = '1;
      set_data(8'h10);
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (bi.out_data !== 8'h10 || bi.out_sel !== 3'd0 || bi.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL manual_idle[%0d]: data=%h sel=%0d valid=%b, required 10/0/1",
                     i, bi.out_data, bi.out_sel, bi.out_valid);
         end
      end
      // mid-stream, between clock edges
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bi.out_data !== 8'h00 || bi.out_valid !== 1'b0 || bi.out_sel !== 3'd0 || bi.sel_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_async: data=%h valid=%b sel=%0d err=%b, required all zero",
                  bi.out_data, bi.out_valid, bi.out_sel, bi.sel_err);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_manual_load();
      apply_reset();
      bi.mode = 1'b0; bi.out_ready = 1'b1; bi.in_valid = '1;
      set_data(8'h10);
      tick();
      tick();
      bi.sel_in = 3'd5; bi.sel_load = 1'b1;
      tick();
      bi.sel_load = 1'b0;
      n_checks++;
      if (bi.out_sel !== 3'd0 || bi.out_data !== 8'h10) begin
         n_fail++;
         $display("FAIL load_edge_t: sel=%0d data=%h, required 0/10", bi.out_sel, bi.out_data);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (bi.out_sel !== 3'd5 || bi.out_data !== 8'h15) begin
            n_fail++;
            $display("FAIL load_after[%0d]: sel=%0d data=%h, required 5/15", i, bi.out_sel, bi.out_data);
         end
      end
   endtask

   task automatic test_scan_wrap();
      int es;
      apply_reset();
      bi.mode = 1'b1; bi.out_ready = 1'b1; bi.in_valid = '1;
      set_data(8'h10);
      for (int k = 0; k <= NCH*DWELL; k++) begin
         tick();
         es = (k / DWELL) % NCH;
         n_checks++;
         if (int'(bi.out_sel) !== es || bi.out_data !== DW'(8'h10 + es)) begin
            n_fail++;
            $display("FAIL scan_wrap[%0d]: sel=%0d data=%h, required %0d/%h",
                     k, bi.out_sel, bi.out_data, es, DW'(8'h10 + es));
         end
      end
   endtask

   task automatic test_backpressure();
      int es;
      apply_reset();
      bi.mode = 1'b1; bi.out_ready = 1'b1; bi.in_valid = '1;
      set_data(8'h40);
      for (int k = 0; k < 6; k++) tick();
      bi.out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         set_data(8'h80 + i*8);
         tick();
         n_checks++;
         if (bi.out_sel !== 3'd1 || bi.out_data !== 8'h41 || bi.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: sel=%0d data=%h valid=%b, required 1/41/1",
                     i, bi.out_sel, bi.out_data, bi.out_valid);
         end
      end
      bi.out_ready = 1'b1;
      for (int j = 0; j < 3; j++) begin
         tick();
         es = (j < 2) ? 1 : 2;
         n_checks++;
         if (int'(bi.out_sel) !== es || bi.out_data !== DW'(8'hA8 + es)) begin
            n_fail++;
            $display("FAIL bp_release[%0d]: sel=%0d data=%h, required %0d/%h",
                     j, bi.out_sel, bi.out_data, es, DW'(8'hA8 + es));
         end
      end
   endtask

   task automatic test_priority_valid();
      int   es;
      logic ev;
      apply_reset();
      bi.mode = 1'b1; bi.out_ready = 1'b1; bi.in_valid = 8'hF7;
      set_data(8'h10);
      for (int k = 0; k < 3; k++) tick();
      bi.sel_in = 3'd2; bi.sel_load = 1'b1;
      tick();
      bi.sel_load = 1'b0;
      n_checks++;
      if (bi.out_sel !== 3'd0) begin
         n_fail++;
         $display("FAIL prio_edge: sel=%0d, required 0", bi.out_sel);
      end
      for (int j = 0; j < 9; j++) begin
         tick();
         es = 2 + j / DWELL;
         ev = (es != 3);
         n_checks++;
         if (int'(bi.out_sel) !== es || bi.out_valid !== ev || bi.out_data !== DW'(8'h10 + es)) begin
            n_fail++;
            $display("FAIL prio_seq[%0d]: sel=%0d valid=%b data=%h, required %0d/%b/%h",
                     j, bi.out_sel, bi.out_valid, bi.out_data, es, ev, DW'(8'h10 + es));
         end
      end
   endtask

   task automatic test_nonpow2();
      apply_reset();
      bj.mode = 1'b1; bj.out_ready = 1'b1; bj.in_valid = '1; bj.sel_load = 1'b0;
      set_data2(8'h20);
      for (int k = 0; k < 12; k++) begin
         tick();
         n_checks++;
         if (int'(bj.out_sel) !== k % NCH2 || bj.out_data !== DW'(8'h20 + k % NCH2)) begin
            n_fail++;
            $display("FAIL nonpow2[%0d]: sel=%0d data=%h, required %0d/%h",
                     k, bj.out_sel, bj.out_data, k % NCH2, DW'(8'h20 + k % NCH2));
         end
      end
   endtask

   task automatic test_sel_err();
      bj.mode = 1'b0;
      bj.sel_in = 3'd3; bj.sel_load = 1'b1;
      tick();
      bj.sel_load = 1'b0;
      n_checks++;
      if (bj.sel_err !== 1'b0) begin
         n_fail++;
         $display("FAIL err_legal: sel_err=%b, required 0", bj.sel_err);
      end
      tick();
      n_checks++;
      if (bj.out_sel !== 3'd3) begin
         n_fail++;
         $display("FAIL err_setup: sel=%0d, required 3", bj.out_sel);
      end
      for (int v = 6; v <= 7; v++) begin
         bj.sel_in = SELW2'(v); bj.sel_load = 1'b1;
         tick();
         bj.sel_load = 1'b0;
         n_checks++;
         if (bj.sel_err !== 1'b1 || bj.out_sel !== 3'd3) begin
            n_fail++;
            $display("FAIL err_pulse[%0d]: sel_err=%b sel=%0d, required 1/3", v, bj.sel_err, bj.out_sel);
         end
         tick();
         n_checks++;
         if (bj.sel_err !== 1'b0 || bj.out_sel !== 3'd3) begin
            n_fail++;
            $display("FAIL err_clear[%0d]: sel_err=%b sel=%0d, required 0/3", v, bj.sel_err, bj.out_sel);
         end
      end
   endtask

   task automatic test_random();
      apply_reset();
      bi.mode = 1'b1; bi.sel_load = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 19) == 0) bi.mode = ~bi.mode;
         bi.sel_load  = ($urandom_range(0, 9) == 0);
         bi.sel_in    = SELW'($urandom);
         bi.out_ready = ($urandom_range(0, 3) != 0);
         bi.in_valid  = NCH'($urandom | $urandom);
         for (int k = 0; k < NCH; k++) bi.in_data[k*DW +: DW] = DW'($urandom);
         tick();
         n_checks++;
         if (bi.out_data !== e_data || bi.out_valid !== e_valid ||
             int'(bi.out_sel) !== e_sel || bi.sel_err !== e_err) begin
            n_fail++;
            $display("FAIL random[%0d]: data=%h valid=%b sel=%0d err=%b, required %h/%b/%0d/%b",
                     c, bi.out_data, bi.out_valid, bi.out_sel, bi.sel_err, e_data, e_valid, e_sel, e_err);
         end
      end
   endtask

   initial begin
      bi.in_data = '0; bi.in_valid = '0; bi.mode = 1'b0; bi.sel_in = '0;
      bi.sel_load = 1'b0; bi.out_ready = 1'b1;
      bj.in_data = '0; bj.in_valid = '0; bj.mode = 1'b0; bj.sel_in = '0;
      bj.sel_load = 1'b0; bj.out_ready = 1'b1;
      model_reset();
      test_reset();
      test_manual_load();
      test_scan_wrap();
      test_backpressure();
      test_priority_valid();
      test_nonpow2();
      test_sel_err();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
